// File: rtl/pg_idle_monitor.sv
// pg_idle_monitor: idle detector and power-down requester in front of the power/clock-gating sequencer.
// Latency: en falls on the edge that samples the idle_threshold-th consecutive idle cycle; traffic in OFF raises en 1 cycle later; status==1 in REQ_ON releases in_stall 1 cycle later.
// Backpressure: in_stall (all bits equal) is held high in every state except ACTIVE; upstream keeps in_valid asserted while stalled.
//
// Ports:
//   ck, rst          clock, synchronous active-high reset
//   in_valid[N_IN]   upstream per-channel valid (activity + wake source)
//   act_busy         domain-internal activity
//   status           sequencer status, 1 = domain fully on
//   idle_threshold   idle cycles before power-down, 0 = never power down
//   en               to sequencer: 1 = keep/bring on, 0 = request power-down
//   in_stall[N_IN]   stall to upstream producers
//   wake_pending     traffic was seen while the power-down request was in flight
//   err              sticky: sequencer reported "not on" while we believed it was on
//   pd_count[16]     power-down request counter, only when PG_EVENT_CNT_EN is defined
//
// Optional build macro: PG_EVENT_CNT_EN adds pd_count, a saturating count of
// ACTIVE->REQ_OFF transitions. Without it the port and counter do not exist.

module pg_idle_monitor #(
    parameter int N_IN   = 2,
    parameter int IDLE_W = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [N_IN-1:0]   in_valid,
    input  logic              act_busy,
    input  logic              status,
    input  logic [IDLE_W-1:0] idle_threshold,
    output logic              en,
    output logic [N_IN-1:0]   in_stall,
    output logic              wake_pending,
    output logic              err
`ifdef PG_EVENT_CNT_EN
    ,
    output logic [15:0]       pd_count
`endif
);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_REQ_OFF = 2'd1,
        ST_OFF     = 2'd2,
        ST_REQ_ON  = 2'd3
    } state_t;

    state_t            r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_en;
    logic              r_stall;
    logic              r_wake_pending;
    logic              r_err;
`ifdef PG_EVENT_CNT_EN
    logic [15:0]       r_pd_count;
`endif

    logic              w_any_valid;
    logic              w_activity;
    logic              w_idle_sat;
    logic [IDLE_W-1:0] w_thr_m1;
    logic              w_thr_hit;

    assign w_any_valid = |in_valid;
    assign w_activity  = w_any_valid | act_busy;
    assign w_idle_sat  = &r_idle_cnt;
    assign w_thr_m1    = idle_threshold - IDLE_W'(1);
    // Compare the count *before* this idle cycle against threshold-1 so the
    // request leaves on the edge that samples the threshold-th idle cycle.
    // Threshold zero would alias to all-ones, so it is excluded explicitly.
    assign w_thr_hit   = (idle_threshold != '0) && (r_idle_cnt == w_thr_m1);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state        <= ST_ACTIVE;
            r_idle_cnt     <= '0;
            r_en           <= 1'b1;
            r_stall        <= 1'b0;
            r_wake_pending <= 1'b0;
            r_err          <= 1'b0;
`ifdef PG_EVENT_CNT_EN
            r_pd_count     <= 16'd0;
`endif
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    // The sequencer must sit in its on state whenever we are
                    // ACTIVE; anything else is a handshake violation.
                    if (!status) begin
                        r_err <= 1'b1;
                    end
                    if (w_activity) begin
                        // Activity wins over a coincident threshold hit.
                        r_idle_cnt <= '0;
                    end else begin
                        if (!w_idle_sat) begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                        if (w_thr_hit) begin
                            r_state <= ST_REQ_OFF;
                            r_en    <= 1'b0;
                            r_stall <= 1'b1;
`ifdef PG_EVENT_CNT_EN
                            if (r_pd_count != 16'hFFFF) begin
                                r_pd_count <= r_pd_count + 16'd1;
                            end
`endif
                        end
                    end
                end

                ST_REQ_OFF: begin
                    // The sequencer cannot abort once it has left its on
                    // state, so wake traffic is only remembered here and acted
                    // on once status confirms the power-down has started.
                    if (w_any_valid) begin
                        r_wake_pending <= 1'b1;
                    end
                    if (!status) begin
                        if (r_wake_pending || w_any_valid) begin
                            r_state <= ST_REQ_ON;
                            r_en    <= 1'b1;
                        end else begin
                            r_state <= ST_OFF;
                        end
                    end
                end

                ST_OFF: begin
                    // Internal activity cannot occur while gated; only
                    // upstream traffic wakes the domain.
                    if (w_any_valid) begin
                        r_state <= ST_REQ_ON;
                        r_en    <= 1'b1;
                    end
                end

                ST_REQ_ON: begin
                    if (status) begin
                        r_state        <= ST_ACTIVE;
                        r_stall        <= 1'b0;
                        r_wake_pending <= 1'b0;
                        r_idle_cnt     <= '0;
                    end
                end

                default: begin
                    r_state <= ST_ACTIVE;
                    r_en    <= 1'b1;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign en           = r_en;
    assign in_stall     = {N_IN{r_stall}};
    assign wake_pending = r_wake_pending;
    assign err          = r_err;
`ifdef PG_EVENT_CNT_EN
    assign pd_count     = r_pd_count;
`endif

endmodule
